// File: rtl/music_pkg.sv
// Shared constants for the music player datapath: beat rate, default widths
// and the saturation limits of a signed sample.
package music_pkg;

    localparam int BEAT_HZ        = 48;
    localparam int DEF_NUM_VOICES = 3;
    localparam int DEF_NOTE_W     = 6;
    localparam int DEF_DUR_W      = 6;
    localparam int DEF_SAMPLE_W   = 18;

    function automatic int sat_max(input int sample_w);
        return (1 << (sample_w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int sample_w);
        return -(1 << (sample_w - 1));
    endfunction

endpackage

// File: rtl/voice_slot.sv
// One voice: note register plus a beat-driven duration counter.
// A load always wins over a tick, so a freshly loaded voice keeps its full duration.
module voice_slot
    import music_pkg::*;
#(
    parameter int NOTE_W = DEF_NOTE_W,
    parameter int DUR_W  = DEF_DUR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [NOTE_W-1:0] note_i,
    input  logic [DUR_W-1:0]  dur_i,
    input  logic              tick_i,
    output logic [NOTE_W-1:0] note_o,
    output logic [DUR_W-1:0]  count_o,
    output logic              active_o
);

    logic [NOTE_W-1:0] note_q, note_d;
    logic [DUR_W-1:0]  count_q, count_d;

    always_comb begin
        note_d  = note_q;
        count_d = count_q;
        if (load_i) begin
            note_d  = note_i;
            count_d = dur_i;
        end else if (tick_i && count_q != '0) begin
            count_d = count_q - DUR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            note_q  <= '0;
            count_q <= '0;
        end else begin
            note_q  <= note_d;
            count_q <= count_d;
        end
    end

    assign note_o   = note_q;
    assign count_o  = count_q;
    assign active_o = (count_q != '0);

endmodule

// File: rtl/poly_voice_allocator.sv
// Polyphonic front end: places note requests onto a pool of voice slots
// (optionally stealing the shortest one) and mixes the active voices' samples.
module poly_voice_allocator
    import music_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int NOTE_W     = DEF_NOTE_W,
    parameter int DUR_W      = DEF_DUR_W,
    parameter int SAMPLE_W   = DEF_SAMPLE_W,
    parameter bit STEAL      = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           play_enable,
    input  logic                           activate,
    input  logic                           beat,
    input  logic                           load_new_note,
    input  logic [NOTE_W-1:0]              note_to_load,
    input  logic [DUR_W-1:0]               duration,
    output logic                           load_accepted,
    output logic                           load_dropped,
    output logic [NUM_VOICES*NOTE_W-1:0]   voice_note,
    output logic [NUM_VOICES-1:0]          voice_active,
    output logic [NUM_VOICES-1:0]          voice_load,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
    input  logic                           samples_valid,
    output logic [SAMPLE_W-1:0]            mixed_sample,
    output logic                           mixed_valid,
    output logic                           all_done
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int SUM_W = SAMPLE_W + 3;
    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(sat_max(SAMPLE_W));
    localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(sat_min(SAMPLE_W));
    localparam logic [SAMPLE_W-1:0]     OUT_MAX = SAMPLE_W'(sat_max(SAMPLE_W));
    localparam logic [SAMPLE_W-1:0]     OUT_MIN = SAMPLE_W'(sat_min(SAMPLE_W));

    logic [DUR_W-1:0]      count [NUM_VOICES];
    logic [NUM_VOICES-1:0] active;
    logic [NUM_VOICES-1:0] load_vec;
    logic                  tick;
    logic                  any_free, accept, drop;
    logic [IDX_W-1:0]      free_idx, steal_idx, target;

    logic signed [SUM_W-1:0] sum;
    logic [SAMPLE_W-1:0]     sat;

    logic [SAMPLE_W-1:0]   mixed_q, mixed_d;
    logic                  mixed_valid_q, mixed_valid_d;
    logic                  accepted_q, dropped_q;
    logic [NUM_VOICES-1:0] voice_load_q;

    assign tick = beat && activate && play_enable;

    // Freedom is judged on pre-edge counts: a voice expiring on this beat is still busy.
    always_comb begin
        any_free  = 1'b0;
        free_idx  = '0;
        steal_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (count[i] == '0) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (count[i] < count[steal_idx]) steal_idx = IDX_W'(i);
        end
        target   = any_free ? free_idx : steal_idx;
        accept   = load_new_note && (duration != '0) && (any_free || STEAL);
        drop     = load_new_note && !accept;
        load_vec = '0;
        if (accept) load_vec[target] = 1'b1;
    end

    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            voice_slot #(
                .NOTE_W (NOTE_W),
                .DUR_W  (DUR_W)
            ) u_slot (
                .clk      (clk),
                .reset    (reset),
                .load_i   (load_vec[gi]),
                .note_i   (note_to_load),
                .dur_i    (duration),
                .tick_i   (tick),
                .note_o   (voice_note[gi*NOTE_W +: NOTE_W]),
                .count_o  (count[gi]),
                .active_o (active[gi])
            );
        end
    endgenerate

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (active[i]) sum = sum + SUM_W'($signed(voice_samples[i*SAMPLE_W +: SAMPLE_W]));
        end
        if (sum > SUM_MAX)      sat = OUT_MAX;
        else if (sum < SUM_MIN) sat = OUT_MIN;
        else                    sat = sum[SAMPLE_W-1:0];

        mixed_d       = mixed_q;
        mixed_valid_d = samples_valid;
        if (samples_valid) mixed_d = play_enable ? sat : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mixed_q       <= '0;
            mixed_valid_q <= 1'b0;
            accepted_q    <= 1'b0;
            dropped_q     <= 1'b0;
            voice_load_q  <= '0;
        end else begin
            mixed_q       <= mixed_d;
            mixed_valid_q <= mixed_valid_d;
            accepted_q    <= accept;
            dropped_q     <= drop;
            voice_load_q  <= load_vec;
        end
    end

    assign voice_active  = active;
    assign all_done      = ~|active;
    assign voice_load    = voice_load_q;
    assign load_accepted = accepted_q;
    assign load_dropped  = dropped_q;
    assign mixed_sample  = mixed_q;
    assign mixed_valid   = mixed_valid_q;

endmodule

// File: tb/tb_poly_voice_allocator.sv
// Bench: a stealing and a dropping allocator share stimulus; both are checked
// every cycle against a per-voice count/note model, plus directed expectations.
module tb_poly_voice_allocator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, play_enable, activate, beat, load_new_note, samples_valid;
    logic [5:0] note_to_load, duration;
    int         samp [3];
    logic [53:0] voice_samples;

    logic        acc_w  [2];
    logic        drop_w [2];
    logic [17:0] vn_w   [2];
    logic [2:0]  va_w   [2];
    logic [2:0]  vl_w   [2];
    logic [17:0] mix_w  [2];
    logic        mv_w   [2];
    logic        done_w [2];

    always_comb voice_samples = {18'(samp[2]), 18'(samp[1]), 18'(samp[0])};

    poly_voice_allocator #(.STEAL(1'b1)) u_steal (
        .clk(clk), .reset(reset), .play_enable(play_enable), .activate(activate),
        .beat(beat), .load_new_note(load_new_note), .note_to_load(note_to_load),
        .duration(duration), .load_accepted(acc_w[0]), .load_dropped(drop_w[0]),
        .voice_note(vn_w[0]), .voice_active(va_w[0]), .voice_load(vl_w[0]),
        .voice_samples(voice_samples), .samples_valid(samples_valid),
        .mixed_sample(mix_w[0]), .mixed_valid(mv_w[0]), .all_done(done_w[0])
    );

    poly_voice_allocator #(.STEAL(1'b0)) u_drop (
        .clk(clk), .reset(reset), .play_enable(play_enable), .activate(activate),
        .beat(beat), .load_new_note(load_new_note), .note_to_load(note_to_load),
        .duration(duration), .load_accepted(acc_w[1]), .load_dropped(drop_w[1]),
        .voice_note(vn_w[1]), .voice_active(va_w[1]), .voice_load(vl_w[1]),
        .voice_samples(voice_samples), .samples_valid(samples_valid),
        .mixed_sample(mix_w[1]), .mixed_valid(mv_w[1]), .all_done(done_w[1])
    );

    int total = 0;
    int bad   = 0;

    // Reference state: remaining beats and note per voice, plus expected pulses.
    int          m_cnt  [2][3];
    int          m_note [2][3];
    bit          e_acc  [2];
    bit          e_drop [2];
    logic [2:0]  e_vl   [2];
    logic [17:0] e_mix  [2];
    bit          e_mv   [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        int          nc [2][3];
        int          nn [2][3];
        bit          na [2];
        bit          nd [2];
        logic [2:0]  nvl [2];
        logic [17:0] nmix [2];
        bit          nmv [2];
        for (int k = 0; k < 2; k++) begin
            int tgt;
            bit tk;
            int s;
            tgt = -1;
            tk  = beat && activate && play_enable;
            if (load_new_note && duration != 0) begin
                int freeq[$];
                for (int v = 0; v < 3; v++) if (m_cnt[k][v] == 0) freeq.push_back(v);
                if (freeq.size() > 0) tgt = freeq[0];
                else if (k == 0) begin
                    tgt = 0;
                    for (int v = 1; v < 3; v++) if (m_cnt[k][v] < m_cnt[k][tgt]) tgt = v;
                end
            end
            for (int v = 0; v < 3; v++) begin
                nn[k][v] = m_note[k][v];
                nc[k][v] = m_cnt[k][v];
                if (v == tgt) begin
                    nc[k][v] = int'(duration);
                    nn[k][v] = int'(note_to_load);
                end else if (tk && m_cnt[k][v] > 0) begin
                    nc[k][v] = m_cnt[k][v] - 1;
                end
            end
            na[k]  = (tgt >= 0);
            nd[k]  = load_new_note && (tgt < 0);
            nvl[k] = (tgt >= 0) ? 3'(1 << tgt) : 3'b000;
            nmix[k] = e_mix[k];
            nmv[k]  = samples_valid;
            if (samples_valid) begin
                s = 0;
                for (int v = 0; v < 3; v++) if (m_cnt[k][v] > 0) s += samp[v];
                if (s > 131071) s = 131071;
                if (s < -131072) s = -131072;
                nmix[k] = play_enable ? 18'(s) : 18'd0;
            end
            if (reset) begin
                for (int v = 0; v < 3; v++) begin
                    nc[k][v] = 0;
                    nn[k][v] = 0;
                end
                na[k] = 0; nd[k] = 0; nvl[k] = '0; nmix[k] = '0; nmv[k] = 0;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            logic [2:0]  ea;
            logic [17:0] en;
            m_cnt[k] = nc[k];
            m_note[k] = nn[k];
            e_acc[k] = na[k]; e_drop[k] = nd[k]; e_vl[k] = nvl[k];
            e_mix[k] = nmix[k]; e_mv[k] = nmv[k];
            ea = '0;
            en = '0;
            for (int v = 0; v < 3; v++) begin
                ea[v] = (m_cnt[k][v] > 0);
                en[v*6 +: 6] = 6'(m_note[k][v]);
            end
            chk($sformatf("active%0d", k), 64'(va_w[k]), 64'(ea));
            chk($sformatf("note%0d", k), 64'(vn_w[k]), 64'(en));
            chk($sformatf("all_done%0d", k), 64'(done_w[k]), 64'(ea == 3'b000));
            chk($sformatf("accepted%0d", k), 64'(acc_w[k]), 64'(e_acc[k]));
            chk($sformatf("dropped%0d", k), 64'(drop_w[k]), 64'(e_drop[k]));
            chk($sformatf("voice_load%0d", k), 64'(vl_w[k]), 64'(e_vl[k]));
            chk($sformatf("mixed%0d", k), 64'(mix_w[k]), 64'(e_mix[k]));
            chk($sformatf("mixed_valid%0d", k), 64'(mv_w[k]), 64'(e_mv[k]));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic load(input int n, input int d);
        load_new_note = 1'b1;
        note_to_load  = 6'(n);
        duration      = 6'(d);
        step();
        load_new_note = 1'b0;
    endtask

    task automatic beat_once();
        beat = 1'b1;
        step();
        beat = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int v = 0; v < 3; v++) begin
                m_cnt[k][v] = 0;
                m_note[k][v] = 0;
            end
            e_mix[k] = '0;
        end
        reset = 1'b1; play_enable = 1'b1; activate = 1'b1; beat = 1'b0;
        load_new_note = 1'b0; note_to_load = '0; duration = '0; samples_valid = 1'b0;
        samp[0] = 0; samp[1] = 0; samp[2] = 0;
        step();
        reset = 1'b0;
        chk("reset_all_done", 64'(done_w[0]), 64'd1);

        // basic load, beat every 4 cycles
        load(12, 3);
        chk("basic_active", 64'(va_w[0]), 64'b001);
        chk("basic_note", 64'(vn_w[0][5:0]), 64'd12);
        chk("basic_vload", 64'(vl_w[0]), 64'b001);
        for (int b = 0; b < 3; b++) begin
            beat_once();
            step(); step(); step();
        end
        chk("basic_expired", 64'(done_w[0]), 64'd1);

        // fill order, then steal vs drop
        do_reset();
        load(1, 5); load(2, 2); load(3, 7);
        load(40, 4);
        chk("steal_note", 64'(vn_w[0][11:6]), 64'd40);
        chk("steal_accepted", 64'(acc_w[0]), 64'd1);
        chk("nosteal_dropped", 64'(drop_w[1]), 64'd1);
        chk("nosteal_note", 64'(vn_w[1][11:6]), 64'd2);

        // load on the beat that expires voice0
        do_reset();
        load(5, 1);
        beat = 1'b1;
        load(6, 3);
        beat = 1'b0;
        chk("coinc_active", 64'(va_w[0]), 64'b010);
        chk("coinc_note", 64'(vn_w[0][11:6]), 64'd6);

        // zero duration, then freeze across 5 beats
        load(7, 0);
        chk("zero_dur_drop", 64'(drop_w[0]), 64'd1);
        chk("zero_dur_active", 64'(va_w[0]), 64'b010);
        play_enable = 1'b0;
        for (int b = 0; b < 5; b++) begin
            beat_once();
            step();
        end
        play_enable = 1'b1;
        chk("freeze_active", 64'(va_w[0]), 64'b010);

        // mix saturation
        do_reset();
        load(1, 20); load(2, 20); load(3, 20);
        samples_valid = 1'b1;
        samp[0] = 100000; samp[1] = 100000; samp[2] = 100000;
        step();
        chk("mix_pos_sat", 64'(mix_w[0]), 64'h1FFFF);
        samp[0] = -131072; samp[1] = -131072; samp[2] = -131072;
        step();
        chk("mix_neg_sat", 64'(mix_w[0]), 64'h20000);
        samples_valid = 1'b0;
        do_reset();
        load(1, 9); load(2, 1); load(3, 9);
        beat_once();
        samples_valid = 1'b1;
        samp[0] = 1000; samp[1] = 5000; samp[2] = -200;
        step();
        chk("mix_inactive", 64'(mix_w[0]), 64'd800);
        samples_valid = 1'b0;

        // reset mid-note with a same-cycle load
        do_reset();
        load(8, 10); load(9, 10);
        reset = 1'b1;
        load_new_note = 1'b1; note_to_load = 6'd11; duration = 6'd5;
        samples_valid = 1'b1;
        step();
        reset = 1'b0; load_new_note = 1'b0; samples_valid = 1'b0;
        chk("rst_active", 64'(va_w[0]), 64'd0);
        chk("rst_done", 64'(done_w[0]), 64'd1);
        chk("rst_mix", 64'(mix_w[0]), 64'd0);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            reset         = ($urandom_range(0, 99) == 0);
            play_enable   = ($urandom_range(0, 9) != 0);
            activate      = ($urandom_range(0, 9) != 0);
            beat          = ($urandom_range(0, 3) == 0);
            load_new_note = ($urandom_range(0, 2) == 0);
            note_to_load  = 6'($urandom_range(0, 63));
            duration      = 6'($urandom_range(0, 12));
            samples_valid = $urandom_range(0, 1) == 1;
            for (int v = 0; v < 3; v++) samp[v] = int'($urandom_range(0, 262143)) - 131072;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
